bin2x2_downscaler: RTL and testbench
====================================

Name: bin2x2_downscaler

Overview:
- Sits directly downstream of timing_generator in the sensor clock domain.
- Consumes the sensor-side active pixel stream: img1_light, img_enable, sync_line_sensor and sync_frame_sensor.
- Produces a 2x2 box-binned stream at half resolution in each axis: 3840x2160 in, 1920x1080 out.
- Output carries a pixel-valid strobe plus start-of-line and start-of-frame markers, ready for the interface-side formatter.

Parameters:
- PIX_W, 8, pixel bit width (matches img1_light).
- ACTIVE_PIX_IN, 3840, maximum enabled pixels accepted per input line.
- ACTIVE_LINE_IN, 2160, maximum input lines accepted per frame.
- CNT_W, 12, width of the pixel and line counters.

Ports:
- clk_gen  input  1  sensor pixel clock; all logic is on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- img1_light  input  PIX_W  input pixel; sampled when img_enable=1.
- img_enable  input  1  input pixel valid; high throughout each active line run.
- sync_frame_sensor  input  1  frame sync; its rising edge marks frame start.
- sync_line_sensor  input  1  line sync; monitored only for the error check.
- bin_pix  output  PIX_W  binned pixel.
- bin_valid  output  1  one-cycle strobe; bin_pix is valid while high.
- bin_sol  output  1  high with the first bin_valid of each output line.
- bin_sof  output  1  high with the first bin_valid of each output frame.
- bin_err  output  1  sticky format error; cleared at frame start.

Behaviour:
- Reset (reset=0), applied asynchronously:
  - All outputs go to 0.
  - Column counter, row counter, row parity, held-pixel register and pipeline registers go to 0.
  - Line buffer contents are not cleared; every odd row reads only locations written by the preceding even row.
- Frame start (rising edge of sync_frame_sensor, detected by a one-cycle delayed copy):
  - Row counter := 0, parity := even, column counter := 0, bin_err := 0.
  - Arms the sof flag.
  - If img_enable=1 in the same cycle, frame start wins and that pixel is column 0 of row 0.
- Line end (falling edge of img_enable):
  - Column counter := 0, parity toggles, row counter increments.
  - Arms the sol flag only when the line just completed was odd.
- Column processing, per enabled pixel:
  - Even column: load the held register.
  - Odd column: hsum = held + img1_light, computed at PIX_W+1 bits.
- Even row: write hsum to linebuf[col>>1]. The buffer is ACTIVE_PIX_IN/2 words of PIX_W+1 bits, one write port and one registered read port.
- Odd row:
  - Read linebuf[col>>1]; sum = rd + hsum at PIX_W+2 bits.
  - bin_pix = sum>>2, or the rounded value when BIN_ROUND_EN is defined.
- Latency: bin_valid asserts exactly 2 clk_gen cycles after the odd-column pixel of an odd row is sampled.
- Throughput: at most one output per 2 input pixels; no backpressure.
- bin_sol and bin_sof:
  - Each asserts on the next bin_valid after its flag is armed, then the flag clears.
  - The first output line of a frame therefore has both set.
- Boundary conditions:
  - Odd pixel count in a line: the trailing held pixel is dropped and no output is produced for it.
  - Column counter reaching ACTIVE_PIX_IN: further pixels in that line are ignored and bin_err := 1.
  - Row counter reaching ACTIVE_LINE_IN: further lines are ignored and bin_err := 1.
  - Odd number of lines in a frame: the last even row is written but never output.
  - sync_line_sensor=1 while img_enable=1: bin_err := 1.
  - Reset mid-line: output stops immediately; the block resumes only after the next frame-start edge. Before that edge the row/column counters hold at 0 and no outputs are produced.

Optional Feature:
- BIN_ROUND_EN defined: bin_pix = (sum + 2) >> 2, round-half-up. Because the maximum sum is 4*255=1020, sum+2 never exceeds 1022, so the result never overflows PIX_W.
- BIN_ROUND_EN not defined: bin_pix = sum >> 2, truncation.

Decomposition:
- Shared package holds:
  - the sensor geometry constants (3840/2160/3920/2211), the interface geometry constants (1920/1200/2000/1252) and the counter-width constant;
  - a typedef for the binned-pixel sideband struct {pix, valid, sol, sof}.
- One sub-module, bin_line_buffer: single write port, single registered read port, depth ACTIVE_PIX_IN/2, width PIX_W+1. It is inferred as block RAM.

Test Plan:
- Flat field: constant 100 over a 3840x2160 frame -> 1920x1080 outputs, all bin_pix=100, exactly 1080 bin_sol and 1 bin_sof.
- Rounding: 2x2 block 1,1,1,2 (sum 5) -> bin_pix=1 with BIN_ROUND_EN undefined and with it defined ((5+2)>>2=1). Block 1,2,2,2 (sum 7) -> 1 without, 2 with.
- Saturation and latency: all pixels 255 -> bin_pix=255 with no wrap. Measure the first bin_valid exactly 2 cycles after sampling row 1, column 1.
- Overlong line: 3842 enabled pixels in row 0 -> bin_err=1, only 1920 outputs from rows 0-1. bin_err clears at the next sync_frame_sensor rising edge.
- Reset mid-frame: assert reset=0 during row 501 -> all outputs 0 within the same cycle. After release, no bin_valid until the next frame start; the following frame is bit-exact.
- Coincident frame start and pixel: sync_frame_sensor rise in the same cycle as img_enable=1, px=40 -> that pixel is treated as column 0 of row 0, and bin_sof marks the first output.

Source files
------------

// File: rtl/bin2x2_downscaler_pkg.sv
// Shared geometry constants and binned-pixel sideband type for the 2x2 downscaler.
package bin2x2_downscaler_pkg;

  localparam int unsigned SENS_H_ACTIVE = 3840;
  localparam int unsigned SENS_V_ACTIVE = 2160;
  localparam int unsigned SENS_H_TOTAL  = 3920;
  localparam int unsigned SENS_V_TOTAL  = 2211;

  localparam int unsigned IF_H_ACTIVE   = 1920;
  localparam int unsigned IF_V_ACTIVE   = 1200;
  localparam int unsigned IF_H_TOTAL    = 2000;
  localparam int unsigned IF_V_TOTAL    = 1252;

  localparam int unsigned CNT_W_DEF     = 12;
  localparam int unsigned PIX_W_DEF     = 8;

  typedef struct packed {
    logic [PIX_W_DEF-1:0] pix;
    logic                 valid;
    logic                 sol;
    logic                 sof;
  } bin_side_t;

endpackage

// File: rtl/bin2x2_downscaler_bin_line_buffer.sv
// One-write, one-registered-read line store holding horizontal pair sums of an even row.
module bin_line_buffer #(
  parameter int unsigned DEPTH = 1920,
  parameter int unsigned WIDTH = 9,
  parameter int unsigned AW    = 11
) (
  input  logic             clk_gen,
  input  logic             we,
  input  logic [AW-1:0]    addr_w,
  input  logic [WIDTH-1:0] data_w,
  input  logic             re,
  input  logic [AW-1:0]    addr_r,
  output logic [WIDTH-1:0] data_r
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset: every read location is rewritten by the preceding even row.
  always_ff @(posedge clk_gen) begin
    if (we) mem[addr_w] <= data_w;
    if (re) data_r <= mem[addr_r];
  end

endmodule

// File: rtl/bin2x2_downscaler.sv
// 2x2 box-binning downscaler for the sensor pixel stream.
// Optional BIN_ROUND_EN selects round-half-up instead of truncation.
module bin2x2_downscaler
  import bin2x2_downscaler_pkg::*;
#(
  parameter int unsigned PIX_W          = PIX_W_DEF,
  parameter int unsigned ACTIVE_PIX_IN  = SENS_H_ACTIVE,
  parameter int unsigned ACTIVE_LINE_IN = SENS_V_ACTIVE,
  parameter int unsigned CNT_W          = CNT_W_DEF
) (
  input  logic             clk_gen,
  input  logic             reset,
  input  logic [PIX_W-1:0] img1_light,
  input  logic             img_enable,
  input  logic             sync_frame_sensor,
  input  logic             sync_line_sensor,
  output logic [PIX_W-1:0] bin_pix,
  output logic             bin_valid,
  output logic             bin_sol,
  output logic             bin_sof,
  output logic             bin_err
);

  localparam int unsigned BUF_D = ACTIVE_PIX_IN / 2;
  localparam int unsigned AW    = (BUF_D > 1) ? $clog2(BUF_D) : 1;
  localparam int unsigned HW    = PIX_W + 1;
  localparam int unsigned SW    = PIX_W + 2;

  logic             sof_d, en_d, active, parity, err;
  logic             sof_flag, sol_flag;
  logic [CNT_W-1:0] col, row;
  logic [PIX_W-1:0] held;
  logic             s1_valid, s1_sol, s1_sof;
  logic [HW-1:0]    s1_hsum;
  logic             s2_valid, s2_sol, s2_sof;
  logic [SW-1:0]    s2_sum;
  bin_side_t        out_q;

  logic             frame_start, run, line_end, par_eff, odd_col;
  logic             pix_ok, ovf, wr_en, rd_en;
  logic [CNT_W-1:0] col_eff, row_eff;
  logic [AW-1:0]    buf_addr;
  logic [HW-1:0]    hsum, rd_data;
  logic [SW-1:0]    sum;
  logic [PIX_W-1:0] scaled_pix;

  // Frame start overrides the current position so a coincident pixel is column 0 of row 0.
  always_comb begin
    frame_start = sync_frame_sensor & ~sof_d;
    run         = active | frame_start;
    line_end    = run & ~frame_start & en_d & ~img_enable;
    col_eff     = frame_start ? '0 : col;
    row_eff     = frame_start ? '0 : row;
    par_eff     = frame_start ? 1'b0 : parity;
    odd_col     = col_eff[0];
    pix_ok      = run & img_enable & (row_eff < CNT_W'(ACTIVE_LINE_IN))
                  & (col_eff < CNT_W'(ACTIVE_PIX_IN));
    ovf         = run & img_enable & ~pix_ok;
    hsum        = HW'(held) + HW'(img1_light);
    buf_addr    = AW'(col_eff >> 1);
    wr_en       = pix_ok & odd_col & ~par_eff;
    rd_en       = pix_ok & odd_col & par_eff;
    sum         = SW'(rd_data) + SW'(s1_hsum);
`ifdef BIN_ROUND_EN
    scaled_pix  = PIX_W'((s2_sum + SW'(2)) >> 2);
`else
    scaled_pix  = PIX_W'(s2_sum >> 2);
`endif
  end

  bin_line_buffer #(
    .DEPTH (BUF_D),
    .WIDTH (HW),
    .AW    (AW)
  ) u_line_buffer (
    .clk_gen (clk_gen),
    .we      (wr_en),
    .addr_w  (buf_addr),
    .data_w  (hsum),
    .re      (rd_en),
    .addr_r  (buf_addr),
    .data_r  (rd_data)
  );

  always_ff @(posedge clk_gen or negedge reset) begin
    if (!reset) begin
      sof_d    <= 1'b0;
      en_d     <= 1'b0;
      active   <= 1'b0;
      col      <= '0;
      row      <= '0;
      parity   <= 1'b0;
      held     <= '0;
      err      <= 1'b0;
      sof_flag <= 1'b0;
      sol_flag <= 1'b0;
      s1_valid <= 1'b0;
      s1_sol   <= 1'b0;
      s1_sof   <= 1'b0;
      s1_hsum  <= '0;
      s2_valid <= 1'b0;
      s2_sol   <= 1'b0;
      s2_sof   <= 1'b0;
      s2_sum   <= '0;
      out_q    <= '0;
    end else begin
      sof_d <= sync_frame_sensor;
      en_d  <= img_enable;

      if (frame_start) begin
        active   <= 1'b1;
        col      <= '0;
        row      <= '0;
        parity   <= 1'b0;
        err      <= 1'b0;
        sof_flag <= 1'b1;
        sol_flag <= 1'b1;
      end else if (line_end && (row < CNT_W'(ACTIVE_LINE_IN))) begin
        col    <= '0;
        parity <= ~parity;
        row    <= row + CNT_W'(1);
        if (parity) sol_flag <= 1'b1;
      end

      if (pix_ok) begin
        col <= col_eff + CNT_W'(1);
        if (!odd_col) held <= img1_light;
      end

      if (ovf || (run && img_enable && sync_line_sensor)) err <= 1'b1;

      // Markers are attached when the output is issued, so late line ends cannot steal them.
      s1_valid <= rd_en;
      s1_sol   <= rd_en & sol_flag;
      s1_sof   <= rd_en & sof_flag;
      if (rd_en) begin
        s1_hsum  <= hsum;
        sol_flag <= 1'b0;
        sof_flag <= 1'b0;
      end

      s2_valid <= s1_valid;
      s2_sol   <= s1_sol;
      s2_sof   <= s1_sof;
      s2_sum   <= sum;

      out_q.pix   <= s2_valid ? PIX_W_DEF'(scaled_pix) : '0;
      out_q.valid <= s2_valid;
      out_q.sol   <= s2_valid & s2_sol;
      out_q.sof   <= s2_valid & s2_sof;
    end
  end

  assign bin_pix   = PIX_W'(out_q.pix);
  assign bin_valid = out_q.valid;
  assign bin_sol   = out_q.sol;
  assign bin_sof   = out_q.sof;
  assign bin_err   = err;

endmodule

// File: tb/tb_bin2x2_downscaler.sv
// Directed bench for bin2x2_downscaler on a reduced 8x6 geometry.
module tb_bin2x2_downscaler;

  logic       clk_gen = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] img1_light = '0;
  logic       img_enable = 1'b0;
  logic       sync_frame_sensor = 1'b0;
  logic       sync_line_sensor = 1'b0;
  logic [7:0] bin_pix;
  logic       bin_valid, bin_sol, bin_sof, bin_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int col1_edge = 0;
  int px[8];
  int expv[8];
  logic [9:0] oq[$];
  int ocyc[$];

  bin2x2_downscaler #(
    .PIX_W(8), .ACTIVE_PIX_IN(8), .ACTIVE_LINE_IN(6), .CNT_W(12)
  ) dut (
    .clk_gen(clk_gen), .reset(reset), .img1_light(img1_light),
    .img_enable(img_enable), .sync_frame_sensor(sync_frame_sensor),
    .sync_line_sensor(sync_line_sensor), .bin_pix(bin_pix),
    .bin_valid(bin_valid), .bin_sol(bin_sol), .bin_sof(bin_sof), .bin_err(bin_err)
  );

  always #5 clk_gen = ~clk_gen;
  always @(posedge clk_gen) cyc <= cyc + 1;

  always @(negedge clk_gen) begin
    if (bin_valid) begin
      oq.push_back({bin_pix, bin_sol, bin_sof});
      ocyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic frame_pulse();
    @(negedge clk_gen);
    sync_frame_sensor = 1'b1;
    @(negedge clk_gen);
    sync_frame_sensor = 1'b0;
  endtask

  task automatic drive_row(input int n, input int cval, input bit use_arr, input bit lsync);
    for (int k = 0; k < n; k++) begin
      @(negedge clk_gen);
      img_enable = 1'b1;
      img1_light = use_arr ? 8'(px[k]) : 8'(cval);
      sync_line_sensor = lsync && (k == 2);
      if (k == 1) col1_edge = cyc + 1;
    end
    @(negedge clk_gen);
    img_enable = 1'b0;
    img1_light = '0;
    sync_line_sensor = 1'b0;
    repeat (4) @(negedge clk_gen);
  endtask

  task automatic clear_q();
    oq.delete();
    ocyc.delete();
  endtask

  initial begin
    int nsol, nsof;
    repeat (2) @(negedge clk_gen);
    chk("rst_pix", 32'(bin_pix), 0);
    chk("rst_valid", 32'(bin_valid), 0);
    chk("rst_sol", 32'(bin_sol), 0);
    chk("rst_sof", 32'(bin_sof), 0);
    chk("rst_err", 32'(bin_err), 0);
    reset = 1'b1;

    // No frame start yet: nothing may come out.
    drive_row(8, 77, 1'b0, 1'b0);
    drive_row(8, 77, 1'b0, 1'b0);
    chk("pre_sof_count", 32'(oq.size()), 0);
    chk("pre_sof_err", 32'(bin_err), 0);
    clear_q();

    // Frame A: rounding, saturation, latency.
    frame_pulse();
    px = '{1, 1, 1, 2, 255, 255, 0, 0};
    drive_row(8, 0, 1'b1, 1'b0);
    px = '{1, 2, 2, 2, 255, 255, 4, 4};
    drive_row(8, 0, 1'b1, 1'b0);
    chk("A_latency", 32'(ocyc.size() > 0 ? ocyc[0] : -1), 32'(col1_edge + 2));
    px = '{10, 20, 30, 40, 50, 60, 70, 80};
    drive_row(8, 0, 1'b1, 1'b0);
    drive_row(8, 2, 1'b0, 1'b0);
`ifdef BIN_ROUND_EN
    expv = '{1, 2, 255, 2, 9, 19, 29, 39};
`else
    expv = '{1, 1, 255, 2, 8, 18, 28, 38};
`endif
    chk("A_count", 32'(oq.size()), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("A_pix%0d", i), 32'(oq[i][9:2]), 32'(expv[i]));
      chk($sformatf("A_sol%0d", i), 32'(oq[i][1]), 32'((i == 0 || i == 4) ? 1 : 0));
      chk($sformatf("A_sof%0d", i), 32'(oq[i][0]), 32'((i == 0) ? 1 : 0));
    end
    clear_q();

    // Frame B: overlong first line.
    frame_pulse();
    chk("B_err_start", 32'(bin_err), 0);
    drive_row(10, 4, 1'b0, 1'b0);
    chk("B_err_overlong", 32'(bin_err), 1);
    drive_row(8, 8, 1'b0, 1'b0);
    chk("B_count", 32'(oq.size()), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("B_pix%0d", i), 32'(oq[i][9:2]), 6);
    clear_q();

    // Frame C: odd pixel count and odd line count.
    frame_pulse();
    chk("C_err_cleared", 32'(bin_err), 0);
    drive_row(5, 12, 1'b0, 1'b0);
    drive_row(5, 16, 1'b0, 1'b0);
    drive_row(8, 20, 1'b0, 1'b0);
    chk("C_count", 32'(oq.size()), 2);
    chk("C_pix0", 32'(oq[0][9:2]), 14);
    chk("C_pix1", 32'(oq[1][9:2]), 14);
    chk("C_err", 32'(bin_err), 0);
    clear_q();

    // Frame D: frame start coincident with the first pixel (row counter left odd by C).
    @(negedge clk_gen);
    sync_frame_sensor = 1'b1;
    img_enable = 1'b1;
    img1_light = 8'd40;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk_gen);
      sync_frame_sensor = 1'b0;
      img1_light = '0;
    end
    @(negedge clk_gen);
    img_enable = 1'b0;
    repeat (4) @(negedge clk_gen);
    drive_row(8, 0, 1'b0, 1'b0);
    chk("D_count", 32'(oq.size()), 4);
    chk("D_pix0", 32'(oq[0][9:2]), 10);
    chk("D_sof0", 32'(oq[0][0]), 1);
    chk("D_sol0", 32'(oq[0][1]), 1);
    chk("D_pix1", 32'(oq[1][9:2]), 0);
    clear_q();

    // Frame E: row limit.
    frame_pulse();
    for (int r = 0; r < 6; r++) drive_row(8, 3, 1'b0, 1'b0);
    chk("E_err_at_limit", 32'(bin_err), 0);
    drive_row(8, 3, 1'b0, 1'b0);
    chk("E_err_over_limit", 32'(bin_err), 1);
    chk("E_count", 32'(oq.size()), 12);
    nsol = 0;
    nsof = 0;
    for (int i = 0; i < oq.size(); i++) begin
      nsol += int'(oq[i][1]);
      nsof += int'(oq[i][0]);
      chk($sformatf("E_pix%0d", i), 32'(oq[i][9:2]), 3);
    end
    chk("E_sol_count", 32'(nsol), 3);
    chk("E_sof_count", 32'(nsof), 1);
    clear_q();

    // Frame F: line sync during active pixels.
    frame_pulse();
    chk("F_err_start", 32'(bin_err), 0);
    drive_row(8, 5, 1'b0, 1'b1);
    chk("F_err_lsync", 32'(bin_err), 1);
    clear_q();

    // Reset in the middle of an output row.
    frame_pulse();
    drive_row(8, 50, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_gen);
      img_enable = 1'b1;
      img1_light = 8'd60;
    end
    @(posedge clk_gen);
    #1;
    chk("R_valid_before", 32'(bin_valid), 1);
    chk("R_pix_before", 32'(bin_pix), 55);
    reset = 1'b0;
    img_enable = 1'b0;
    img1_light = '0;
    #1;
    chk("R_valid_async", 32'(bin_valid), 0);
    chk("R_pix_async", 32'(bin_pix), 0);
    chk("R_sof_async", 32'(bin_sof), 0);
    chk("R_sol_async", 32'(bin_sol), 0);
    @(negedge clk_gen);
    reset = 1'b1;
    clear_q();
    drive_row(8, 9, 1'b0, 1'b0);
    drive_row(8, 9, 1'b0, 1'b0);
    chk("R_no_out_after", 32'(oq.size()), 0);
    frame_pulse();
    px = '{0, 4, 8, 12, 16, 20, 24, 28};
    drive_row(8, 0, 1'b1, 1'b0);
    px = '{1, 3, 5, 7, 9, 11, 13, 15};
    drive_row(8, 0, 1'b1, 1'b0);
    expv = '{2, 8, 14, 20, 0, 0, 0, 0};
    chk("R_count", 32'(oq.size()), 4);
    for (int i = 0; i < 4; i++) chk($sformatf("R_pix%0d", i), 32'(oq[i][9:2]), 32'(expv[i]));
    chk("R_sof0", 32'(oq[0][0]), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
